// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
package if_fetch_pkg;

   // Fetch FSM: issue a request, then wait for its read data.
   typedef enum logic {
      S_REQ,
      S_RESP
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;
   localparam int unsigned PC_INC       = 4;

endpackage

// File: rtl/if_fetch_buf.sv
// One-entry {pc, inst, valid} holding buffer between fetch and IF/ID.
module if_fetch_buf #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned INST_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              consume_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] load_pc_i,
   input  logic [INST_W-1:0] load_inst_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic [INST_W-1:0] inst_o
);

   logic              valid_q;
   logic [ADDR_W-1:0] pc_q;
   logic [INST_W-1:0] inst_q;

   // Flush beats load beats consume; a load in the consume cycle refills the entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         inst_q  <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         pc_q    <= load_pc_i;
         inst_q  <= load_inst_i;
      end else if (consume_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign inst_o  = inst_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over req/gnt + rvalid, applies
// redirects and presents one buffered {pc, inst} to the IF/ID register.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        pause,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_pc,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_pc,
   output logic              inst_req,
   output logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_gnt,
   input  logic              inst_rvalid,
   input  logic [INST_W-1:0] inst_rdata,
   output logic [ADDR_W-1:0] if_pc,
   output logic [INST_W-1:0] if_inst,
   output logic              pause_req_if
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              discard_q, discard_d;
   logic              redir_pend_q, redir_pend_d;
   logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

   logic              out_valid;
   logic [ADDR_W-1:0] buf_pc;
   logic [INST_W-1:0] buf_inst;
   logic              buf_load, buf_flush, buf_consume;
   logic              redir;
   logic [ADDR_W-1:0] redir_pc;
   logic              rst_discard;
   logic              unused_pause;

   assign unused_pause = ^pause[5:2];

   assign redir       = flush | branch_flag;
   assign redir_pc    = flush ? flush_pc : branch_pc;
   assign buf_consume = out_valid & ~pause[1];

   // A discard flag in S_REQ marks a stale response still owed by memory; hold off
   // new requests until it has drained so responses cannot be mismatched.
   assign inst_req  = ~rst & (state_q == S_REQ) & ~discard_q & ~pause[0]
                    & (~out_valid | ~pause[1]);
   assign inst_addr = {pc_q[ADDR_W-1:2], 2'b00};

   // Reset abandons an in-flight transaction; its late rvalid must be swallowed.
   assign rst_discard = ((state_q == S_RESP) | discard_q) & ~inst_rvalid;

   // State register and PC; reset has priority over every redirect.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         discard_q    <= rst_discard;
         redir_pend_q <= 1'b0;
         pend_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         discard_q    <= discard_d;
         redir_pend_q <= redir_pend_d;
         pend_pc_q    <= pend_pc_d;
      end
   end

   // Next-state, redirect handling and buffer control.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      discard_d    = discard_q;
      redir_pend_d = redir_pend_q;
      pend_pc_d    = pend_pc_q;
      buf_load     = 1'b0;
      buf_flush    = redir;
      unique case (state_q)
         S_REQ: begin
            if (discard_q && inst_rvalid) begin
               discard_d = 1'b0;
            end
            if (redir) begin
               if (inst_req && inst_gnt) begin
                  state_d      = S_RESP;
                  discard_d    = 1'b1;
                  redir_pend_d = 1'b1;
                  pend_pc_d    = redir_pc;
               end else begin
                  pc_d = redir_pc;
               end
            end else if (inst_req && inst_gnt) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (inst_rvalid) begin
               state_d      = S_REQ;
               discard_d    = 1'b0;
               redir_pend_d = 1'b0;
               if (redir) begin
                  pc_d = redir_pc;
               end else if (discard_q) begin
                  pc_d = redir_pend_q ? pend_pc_q : pc_q;
               end else begin
                  buf_load = 1'b1;
                  pc_d     = pc_q + ADDR_W'(PC_INC);
               end
            end else if (redir) begin
               discard_d    = 1'b1;
               redir_pend_d = 1'b1;
               pend_pc_d    = redir_pc;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   if_fetch_buf #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W)
   ) u_buf (
      .clk         (clk),
      .rst         (rst),
      .load_i      (buf_load),
      .consume_i   (buf_consume),
      .flush_i     (buf_flush),
      .load_pc_i   (pc_q),
      .load_inst_i (inst_rdata),
      .valid_o     (out_valid),
      .pc_o        (buf_pc),
      .inst_o      (buf_inst)
   );

   assign if_pc        = out_valid ? buf_pc : '0;
   assign if_inst      = out_valid ? buf_inst : '0;
   assign pause_req_if = ~out_valid & ~rst;

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch against a transaction-level fetch model.
module tb_if_fetch;

   localparam logic [31:0] RST_PC = 32'h1c000000;
   localparam int          NCYC   = 3000;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  pause;
   logic        flush, branch_flag;
   logic [31:0] flush_pc, branch_pc;
   logic        inst_req, inst_gnt, inst_rvalid;
   logic [31:0] inst_addr, inst_rdata;
   logic [31:0] if_pc, if_inst;
   logic        pause_req_if;

   always #5 clk = ~clk;

   if_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .pause        (pause),
      .flush        (flush),
      .flush_pc     (flush_pc),
      .branch_flag  (branch_flag),
      .branch_pc    (branch_pc),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_gnt     (inst_gnt),
      .inst_rvalid  (inst_rvalid),
      .inst_rdata   (inst_rdata),
      .if_pc        (if_pc),
      .if_inst      (if_inst),
      .pause_req_if (pause_req_if)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Instruction memory contents as a fixed function of the address.
   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a * 32'h9e3779b1) ^ 32'ha5a50f0f;
   endfunction

   function automatic logic [31:0] pick_target();
      logic [31:0] r;
      r = $urandom();
      case ($urandom_range(0, 3))
         0:       return 32'h1c000100;
         1:       return 32'h1c000800;
         2:       return 32'hfffffff8;
         default: return {r[31:2], 2'b00};
      endcase
   endfunction

   // Memory model: one slot, response 1..4 cycles after grant.
   logic        mem_pending = 1'b0;
   logic [31:0] mem_addr    = '0;
   int          mem_lat     = 0;

   // Reference model state.
   logic        m_valid   = 1'b0;
   logic [31:0] m_pc      = '0;
   logic [31:0] m_inst    = '0;
   logic        m_taint   = 1'b0;
   logic [31:0] exp_fetch = RST_PC;
   int          loads     = 0;

   initial begin
      int p_redir, p_pause, p_gnt, p_rst, max_lat;
      logic rvalid_now, gnt_v, redir, req_s, prev_hold;
      logic [31:0] tgt, addr_s, prev_addr;
      prev_hold = 1'b0;
      prev_addr = '0;
      rst = 1'b1; pause = '0; flush = 1'b0; branch_flag = 1'b0;
      flush_pc = '0; branch_pc = '0; inst_gnt = 1'b0; inst_rvalid = 1'b0; inst_rdata = '0;
      for (int c = 0; c < NCYC; c++) begin
         case (c / 600)
            0:       begin p_redir = 5;  p_pause = 20; p_gnt = 70;  p_rst = 2;  max_lat = 2; end
            1:       begin p_redir = 2;  p_pause = 0;  p_gnt = 100; p_rst = 0;  max_lat = 0; end
            2:       begin p_redir = 30; p_pause = 15; p_gnt = 60;  p_rst = 2;  max_lat = 3; end
            3:       begin p_redir = 5;  p_pause = 50; p_gnt = 25;  p_rst = 2;  max_lat = 3; end
            default: begin p_redir = 10; p_pause = 20; p_gnt = 60;  p_rst = 50; max_lat = 2; end
         endcase
         @(negedge clk);
         rst         = (c < 3) || ($urandom_range(0, 999) < p_rst);
         pause       = 6'($urandom());
         pause[0]    = $urandom_range(0, 99) < p_pause;
         pause[1]    = $urandom_range(0, 99) < p_pause;
         flush       = $urandom_range(0, 99) < p_redir / 2;
         branch_flag = $urandom_range(0, 99) < p_redir;
         flush_pc    = pick_target();
         branch_pc   = pick_target();
         rvalid_now  = mem_pending && (mem_lat == 0);
         inst_rvalid = rvalid_now;
         inst_rdata  = rvalid_now ? mem_data(mem_addr) : $urandom();
         #1;
         if (c > 0) begin
            check_eq("pause_req_if", pause_req_if, !m_valid && !rst);
            check_eq("if_pc", if_pc, m_valid ? m_pc : 32'h0);
            check_eq("if_inst", if_inst, m_valid ? m_inst : 32'h0);
            if (rst) check_eq("req_in_rst", inst_req, 1'b0);
            if (inst_req) check_eq("one_outstanding", mem_pending, 1'b0);
            if (prev_hold && inst_req) check_eq("addr_stable", inst_addr, prev_addr);
         end
         gnt_v = (c > 0) && inst_req && !mem_pending && ($urandom_range(0, 99) < p_gnt);
         if (gnt_v) check_eq("fetch_addr", inst_addr, exp_fetch);
         inst_gnt = gnt_v;
         req_s    = (c > 0) && inst_req;
         addr_s   = inst_addr;
         redir    = flush || branch_flag;
         tgt      = flush ? flush_pc : branch_pc;
         @(posedge clk);
         // Reference model: a response is used only if no redirect or reset
         // touched its transaction between grant and data, inclusive.
         if (rst) begin
            if (mem_pending && !rvalid_now) m_taint = 1'b1;
            m_valid   = 1'b0;
            exp_fetch = RST_PC;
         end else begin
            if (m_valid && !pause[1]) m_valid = 1'b0;
            if (rvalid_now) begin
               if (!m_taint && !redir) begin
                  m_valid   = 1'b1;
                  m_pc      = mem_addr;
                  m_inst    = mem_data(mem_addr);
                  exp_fetch = mem_addr + 32'd4;
                  loads++;
               end
               m_taint = 1'b0;
            end
            if (gnt_v) m_taint = 1'b0;
            if (redir) begin
               exp_fetch = tgt;
               m_valid   = 1'b0;
               if (gnt_v || (mem_pending && !rvalid_now)) m_taint = 1'b1;
            end
         end
         // Memory model advance.
         if (rvalid_now) mem_pending = 1'b0;
         else if (mem_pending) mem_lat--;
         if (gnt_v) begin
            mem_pending = 1'b1;
            mem_addr    = addr_s;
            mem_lat     = $urandom_range(0, max_lat);
         end
         prev_hold = req_s && !gnt_v && !redir && !rst;
         prev_addr = addr_s;
      end
      check_eq("progress", loads >= 150, 1'b1);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
